// File: rtl/booth_radix4_multiplier_if.sv
// booth_radix4_multiplier_if: operand/result handshake bundle for the radix-4 Booth multiplier
//   abort        master->slave  synchronous abort of the operation in flight
//   in_valid     master->slave  m, q, signed_mode are valid
//   in_ready     slave->master  multiplier can accept operands
//   signed_mode  master->slave  1: two's-complement operands, 0: unsigned
//   m, q         master->slave  multiplicand, multiplier (WIDTH bits)
//   out_valid    slave->master  result is valid
//   out_ready    master->slave  consumer takes result
//   result       slave->master  product (2*WIDTH bits)
//   busy         slave->master  operation in CALC or DONE
interface booth_radix4_multiplier_if #(parameter int WIDTH = 32);
   logic               abort;
   logic               in_valid;
   logic               in_ready;
   logic               signed_mode;
   logic [WIDTH-1:0]   m;
   logic [WIDTH-1:0]   q;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] result;
   logic               busy;
   modport master (
      output abort, in_valid, signed_mode, m, q, out_ready,
      input  in_ready, out_valid, result, busy
   );
   modport slave (
      input  abort, in_valid, signed_mode, m, q, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier: sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of booth_radix4_multiplier_if (operand/result handshake, abort, busy)
module booth_radix4_multiplier #(
   parameter int WIDTH = 32
) (
   input logic                       clk,
   input logic                       reset,
   booth_radix4_multiplier_if.slave  bus
);
   localparam int N  = WIDTH / 2 + 1;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t               state, state_nx;
   logic [WIDTH+1:0]     mr, qr;
   logic [WIDTH+3:0]     a, m1, m2, pp, a_sum;
   logic                 q_m1;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   result_r;
   logic signed [2*WIDTH+6:0] sh;
   logic [2:0]           trip;
   logic                 accept, last;
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.result    = result_r;
   // abort in IDLE drops the offered operands
   assign accept = bus.in_valid & bus.in_ready & ~bus.abort;
   assign last   = cnt == CW'(N - 1);
   assign trip   = {qr[1:0], q_m1};
   assign m1     = {{2{mr[WIDTH+1]}}, mr};
   assign m2     = {mr[WIDTH+1], mr, 1'b0};
   always_comb begin
      pp = (trip == 3'b001 || trip == 3'b010) ? m1 :
           (trip == 3'b011)                   ? m2 :
           (trip == 3'b100)                   ? -m2 :
           (trip == 3'b101 || trip == 3'b110) ? -m1 : '0;
   end
   assign a_sum = a + pp;
   // {A,Q,q_m1} arithmetic shift right by two after the partial-product add
   assign sh = $signed({a_sum, qr, q_m1}) >>> 2;
   always_comb begin
      state_nx = state == IDLE ? (accept ? CALC : IDLE) :
                 bus.abort     ? IDLE :
                 state == CALC ? (last ? DONE : CALC) :
                 (bus.out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mr       <= '0;
         qr       <= '0;
         a        <= '0;
         q_m1     <= 1'b0;
         cnt      <= '0;
         result_r <= '0;
      end else if (accept) begin
         mr   <= {{2{bus.signed_mode & bus.m[WIDTH-1]}}, bus.m};
         qr   <= {{2{bus.signed_mode & bus.q[WIDTH-1]}}, bus.q};
         a    <= '0;
         q_m1 <= 1'b0;
         cnt  <= '0;
      end else if (bus.abort) begin
         cnt <= '0;
      end else if (state == CALC) begin
         {a, qr, q_m1} <= sh;
         cnt           <= cnt + 1'b1;
         // the low 2*WIDTH bits of {A,Q} after the final shift hold the exact product
         if (last) result_r <= sh[2*WIDTH:1];
      end
   end
endmodule
